// File: rtl/priority_arbiter_pkg.sv
// Shared state encodings and default parameters for the two-source priority arbiter.
package priority_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN1 = 2'b01,
    ST_OWN2 = 2'b10
  } state_t;

  localparam int unsigned HOLD_MIN_DEF  = 4;
  localparam int unsigned MAX_GRANT_DEF = 16;
  localparam int unsigned CNT_W_DEF     = 5;

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between the two bus sources and the arbiter.
// The arbiter side is the slave; the requesters/downstream buffer logic use master.
interface priority_arbiter_if;
  logic i_req1;
  logic i_req2;
  logic o_priority;
  logic o_use_priority;
  logic o_handover;

  modport slave (
    input  i_req1,
    input  i_req2,
    output o_priority,
    output o_use_priority,
    output o_handover
  );

  modport master (
    output i_req1,
    output i_req2,
    input  o_priority,
    input  o_use_priority,
    input  o_handover
  );
endinterface

// File: rtl/priority_arbiter_hold_counter.sv
// Grant-age counter: clears to zero, counts up while enabled, sticks at MAX_GRANT.
module hold_counter #(
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned MAX_GRANT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Saturating up-counter with synchronous clear and asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_W'(MAX_GRANT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/priority_arbiter.sv
// Two-source bus arbiter: round-robin on simultaneous requests from idle,
// minimum hold time per grant, forced hand-over of a contested grant after
// MAX_GRANT cycles. All outputs are registered Moore outputs.
module priority_arbiter
  import priority_arb_pkg::*;
#(
  parameter int unsigned HOLD_MIN  = HOLD_MIN_DEF,
  parameter int unsigned MAX_GRANT = MAX_GRANT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  priority_arbiter_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rr;
  logic             r_priority;
  logic             r_use_priority;
  logic             r_handover;
  logic [CNT_W-1:0] w_cnt;
  logic             w_state_change;
  logic             w_hold_done;
  logic             w_force;

  assign w_state_change = (w_next_state != r_state);
  assign w_hold_done    = (w_cnt >= CNT_W'(HOLD_MIN - 1));
  assign w_force        = (w_cnt == CNT_W'(MAX_GRANT - 1));

  hold_counter #(
    .CNT_W     (CNT_W),
    .MAX_GRANT (MAX_GRANT)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_clear  (w_state_change),
    .i_enable (1'b1),
    .o_cnt    (w_cnt)
  );

  // Next-state selection; the counter clear is derived from it, so it lives
  // outside the registered block while all state and outputs stay in one always_ff
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req1 && (!bus.i_req2 || !r_rr)) w_next_state = ST_OWN1;
        else if (bus.i_req2)                      w_next_state = ST_OWN2;
        else                                      w_next_state = ST_IDLE;
      end
      ST_OWN1: begin
        if (w_hold_done && !bus.i_req1)
          w_next_state = bus.i_req2 ? ST_OWN2 : ST_IDLE;
        else if (bus.i_req1 && bus.i_req2 && w_force)
          w_next_state = ST_OWN2;
      end
      ST_OWN2: begin
        if (w_hold_done && !bus.i_req2)
          w_next_state = bus.i_req1 ? ST_OWN1 : ST_IDLE;
        else if (bus.i_req1 && bus.i_req2 && w_force)
          w_next_state = ST_OWN1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_rr           <= 1'b0;
      r_priority     <= 1'b1;
      r_use_priority <= 1'b0;
      r_handover     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_state_change && (w_next_state == ST_OWN1)) r_rr <= 1'b1;
      if (w_state_change && (w_next_state == ST_OWN2)) r_rr <= 1'b0;
      r_use_priority <= (w_next_state != ST_IDLE);
      r_priority     <= (w_next_state != ST_OWN2);
      r_handover     <= ((r_state == ST_OWN1) && (w_next_state == ST_OWN2)) ||
                        ((r_state == ST_OWN2) && (w_next_state == ST_OWN1));
    end
  end

  assign bus.o_priority     = r_priority;
  assign bus.o_use_priority = r_use_priority;
  assign bus.o_handover     = r_handover;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed plus randomized checks of priority_arbiter against an owner/age
// reference model evaluated once per clock edge.
module tb_priority_arbiter;
  import priority_arb_pkg::*;

  localparam int HM = 4;
  localparam int MG = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] bad_enc;

  always #5 clk = ~clk;

  priority_arbiter_if bus ();

  priority_arbiter #(
    .HOLD_MIN  (HM),
    .MAX_GRANT (MG),
    .CNT_W     (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: owner 0 = none, 1 = source 1, 2 = source 2;
  // age = cycles the current owner has held the bus (0 in the first cycle).
  int m_owner;
  int m_age;
  bit m_rr;
  bit m_ho;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r1, input bit r2);
    bit req [1:2];
    int prev;
    int nxt;
    int other;
    req[1] = r1;
    req[2] = r2;
    prev = m_owner;
    nxt  = prev;
    if (prev == 0) begin
      if (r1 && r2) nxt = m_rr ? 2 : 1;
      else if (r1)  nxt = 1;
      else if (r2)  nxt = 2;
    end else begin
      other = 3 - prev;
      if (m_age >= HM - 1 && !req[prev])
        nxt = req[other] ? other : 0;
      else if (req[prev] && req[other] && m_age == MG - 1)
        nxt = other;
    end
    if (nxt != prev) begin
      m_age = 0;
      if (nxt == 1) m_rr = 1'b1;
      if (nxt == 2) m_rr = 1'b0;
    end else begin
      m_age++;
    end
    m_ho = (prev != 0) && (nxt != 0) && (prev != nxt);
    m_owner = nxt;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".use_priority"}, bus.o_use_priority, m_owner != 0);
    chk({tag, ".priority"},     bus.o_priority,     m_owner != 2);
    chk({tag, ".handover"},     bus.o_handover,     m_ho);
  endtask

  task automatic step(input bit r1, input bit r2, input string tag);
    bus.i_req1 = r1;
    bus.i_req2 = r2;
    @(posedge clk);
    model_edge(r1, r2);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n    = 1'b0;
    bus.i_req1 = 1'b0;
    bus.i_req2 = 1'b0;
    #2;
    m_owner = 0;
    m_age   = 0;
    m_rr    = 1'b0;
    m_ho    = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int own_cnt;
    int ho_cnt;
    int ho_idx;

    reset_n    = 1'b1;
    bus.i_req1 = 1'b0;
    bus.i_req2 = 1'b0;
    bad_enc    = 2'b11;
    #1;

    // Reset, then source 1 alone for 10 cycles and release
    do_reset("reset");
    own_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, "req1_only");
      if (bus.o_use_priority === 1'b1 && bus.o_priority === 1'b1) own_cnt++;
    end
    chk_int("req1_only.own1_cycles", own_cnt, 10);
    step(1'b0, 1'b0, "req1_drop");
    chk("req1_drop.idle", bus.o_use_priority, 1'b0);

    // Simultaneous requests after reset: OWN1 first, forced hand-over after 16 cycles
    do_reset("reset2");
    own_cnt = 0;
    ho_cnt  = 0;
    ho_idx  = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, "contest");
      if (bus.o_use_priority === 1'b1 && bus.o_priority === 1'b1) own_cnt++;
      if (bus.o_handover === 1'b1) begin
        ho_cnt++;
        if (ho_idx < 0) ho_idx = i;
      end
    end
    chk_int("contest.own1_cycles", own_cnt, 16);
    chk_int("contest.handover_pulses", ho_cnt, 1);
    chk_int("contest.handover_cycle", ho_idx, 16);
    step(1'b0, 1'b0, "contest_release");

    // Single-cycle request from source 2 still gets the minimum hold
    own_cnt = 0;
    step(1'b0, 1'b1, "req2_pulse");
    if (bus.o_use_priority === 1'b1 && bus.o_priority === 1'b0) own_cnt++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, "req2_pulse_tail");
      if (bus.o_use_priority === 1'b1 && bus.o_priority === 1'b0) own_cnt++;
    end
    chk_int("req2_pulse.own2_cycles", own_cnt, 4);

    // Owner drops its request early while the other waits: change only at the hold boundary
    own_cnt = 0;
    step(1'b1, 1'b0, "early_drop");
    if (bus.o_priority === 1'b1 && bus.o_use_priority === 1'b1) own_cnt++;
    step(1'b1, 1'b1, "early_drop");
    if (bus.o_priority === 1'b1 && bus.o_use_priority === 1'b1) own_cnt++;
    step(1'b0, 1'b1, "early_drop");
    if (bus.o_priority === 1'b1 && bus.o_use_priority === 1'b1) own_cnt++;
    step(1'b0, 1'b1, "early_drop");
    if (bus.o_priority === 1'b1 && bus.o_use_priority === 1'b1) own_cnt++;
    step(1'b0, 1'b1, "early_drop_switch");
    chk_int("early_drop.own1_cycles", own_cnt, 4);
    chk("early_drop.priority_low", bus.o_priority, 1'b0);
    chk("early_drop.handover", bus.o_handover, 1'b1);
    step(1'b0, 1'b1, "own2_hold");
    step(1'b0, 1'b1, "own2_hold");

    // Asynchronous reset in the middle of an OWN2 grant, then simultaneous requests
    do_reset("async_reset");
    step(1'b1, 1'b1, "post_reset_both");
    chk("post_reset_both.own1", bus.o_priority, 1'b1);

    // Randomized request patterns
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, "random");
    end

    // Return to idle, then an uncontested grant held well past saturation
    for (int i = 0; i < 20 && m_owner != 0; i++) step(1'b0, 1'b0, "drain");
    chk_int("drain.idle", m_owner, 0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, "saturate_hold");
    chk("saturate_hold.own1", bus.o_use_priority, 1'b1);

    // Illegal state encoding recovers to IDLE on the next edge
    @(negedge clk);
    force dut.r_state = state_t'(bad_enc);
    #1;
    release dut.r_state;
    bus.i_req1 = 1'b1;
    bus.i_req2 = 1'b0;
    @(posedge clk);
    m_owner = 0;
    m_age   = 0;
    m_ho    = 1'b0;
    #1;
    check_outputs("bad_state");
    step(1'b1, 1'b0, "bad_state_recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
